// File: rtl/countdown_arbiter_if.sv
// Bus between the requester blocks and the shared countdown timer.
//   master : requester side, drives req/len/abort, observes grant/status
//   slave  : arbiter side, the reverse
// Parameters: N_REQ requesters, WIDTH-bit lengths and counter.
interface countdown_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] len;
  logic                   abort;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic [WIDTH-1:0]       count;
  logic [N_REQ-1:0]       done;
  logic [7:0]             done_total;
  logic                   warn;

  modport master (
    output req, len, abort,
    input  grant, busy, count, done, done_total, warn
  );

  modport slave (
    input  req, len, abort,
    output grant, busy, count, done, done_total, warn
  );
endinterface

// File: rtl/countdown_arbiter.sv
// Round-robin arbiter sharing one down counter among N_REQ requesters.
// The winner's length is loaded on the grant edge, counted down to zero,
// and a one-cycle done pulse is returned to that requester.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : countdown_arbiter_if.slave (req, len, abort in; grant, busy,
//          count, done, done_total, warn out)
// Optional feature: define TIMER_ARB_WARN_EN to enable the near-expiry
// warn output (busy && count == WARN_LEVEL); otherwise warn is tied low.
module countdown_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
`ifdef TIMER_ARB_WARN_EN
  ,
  parameter int unsigned WARN_LEVEL = 5
`endif
) (
  input logic             clk,
  input logic             rst,
  countdown_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TOT_W = 8;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [TOT_W-1:0]   total_q, total_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   cand;

  // Round-robin pick: first requester at or after last_grant+1, wrapping.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      count_q <= '0;
      total_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      count_q <= count_d;
      total_q <= total_d;
      last_q  <= last_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    count_d = count_q;
    total_d = total_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = N_REQ'(1) << win;
          count_d = bus.len[32'(win) * WIDTH +: WIDTH];
          last_d  = win;
          state_d = RUN;
        end
      end
      RUN: begin
        // abort wins over a completion in the same cycle
        if (bus.abort) begin
          grant_d = '0;
          count_d = '0;
          state_d = IDLE;
        end else if (count_q == '0) begin
          done_d  = grant_q;
          grant_d = '0;
          total_d = total_q + TOT_W'(1);
          state_d = IDLE;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.count      = count_q;
  assign bus.done       = done_q;
  assign bus.done_total = total_q;

`ifdef TIMER_ARB_WARN_EN
  assign bus.warn = (state_q == RUN) && (count_q == WIDTH'(WARN_LEVEL));
`else
  assign bus.warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_arbiter.sv
// Testbench for countdown_arbiter: directed scenarios followed by random
// traffic, all outputs compared every cycle against a job-level reference
// model (owner, grant time and length; count derived from elapsed cycles).
module tb_countdown_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned WL = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  countdown_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  countdown_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int cyc      = 0;
  int owner    = -1;
  int g_cycle  = 0;
  int job_len  = 0;
  int last     = N - 1;
  int total    = 0;
  int m_count  = 0;
  int done_idx = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_edge(input logic [N-1:0] r, input logic [N*W-1:0] l,
                            input logic ab, input logic rs);
    bit found;
    cyc++;
    done_idx = -1;
    if (rs) begin
      owner   = -1;
      last    = N - 1;
      total   = 0;
      m_count = 0;
    end else if (owner < 0) begin
      if (r != '0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (last + k) % N;
          if (!found && r[i]) begin
            found = 1;
            owner = i;
          end
        end
        last    = owner;
        g_cycle = cyc;
        job_len = int'((l >> (owner * W)) & 32'hff);
        m_count = job_len;
      end
    end else if (ab) begin
      owner   = -1;
      m_count = 0;
    end else if (cyc - g_cycle == job_len + 1) begin
      done_idx = owner;
      owner    = -1;
      total    = (total + 1) % 256;
      m_count  = 0;
    end else begin
      m_count = job_len - (cyc - g_cycle);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_warn;
`ifdef TIMER_ARB_WARN_EN
    exp_warn = (owner >= 0 && m_count == WL) ? 32'd1 : 32'd0;
`else
    exp_warn = 32'd0;
`endif
    check("grant", 32'(bus.grant), (owner >= 0) ? (32'd1 << owner) : 32'd0);
    check("busy", 32'(bus.busy), (owner >= 0) ? 32'd1 : 32'd0);
    check("count", 32'(bus.count), 32'(m_count));
    check("done", 32'(bus.done), (done_idx >= 0) ? (32'd1 << done_idx) : 32'd0);
    check("done_total", 32'(bus.done_total), 32'(total));
    check("warn", 32'(bus.warn), exp_warn);
  endtask

  // Drive inputs, clock once, then compare everything against the model.
  task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] l,
                      input logic ab, input logic rs);
    rst       = rs;
    bus.req   = r;
    bus.len   = l;
    bus.abort = ab;
    @(posedge clk);
    model_edge(r, l, ab, rs);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step('0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [N*W-1:0] l;
    logic [N-1:0]   r;
    int             wcnt;
    bit             reached;

    // Single job on requester 0, length 3.
    do_reset();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_total", 32'(bus.done_total), 32'd0);
    l = '0;
    l[7:0] = 8'd3;
    step(4'b0001, l, 1'b0, 1'b0);
    check("sj_grant", 32'(bus.grant), 32'd1);
    check("sj_count_start", 32'(bus.count), 32'd3);
    for (int k = 1; k <= 3; k++) begin
      step('0, l, 1'b0, 1'b0);
      check("sj_count", 32'(bus.count), 32'(3 - k));
    end
    step('0, l, 1'b0, 1'b0);
    check("sj_done", 32'(bus.done), 32'd1);
    check("sj_total", 32'(bus.done_total), 32'd1);
    check("sj_grant_off", 32'(bus.grant), 32'd0);
    step('0, l, 1'b0, 1'b0);
    check("sj_done_off", 32'(bus.done), 32'd0);

    // Round-robin with all requesters asserted and zero lengths.
    do_reset();
    for (int j = 0; j < 5; j++) begin
      step(4'b1111, '0, 1'b0, 1'b0);
      check("rr_grant", 32'(bus.grant), 32'd1 << (j % N));
      step(4'b1111, '0, 1'b0, 1'b0);
      check("rr_done", 32'(bus.done), 32'd1 << (j % N));
    end

    // Abort requester 2 at count 6.
    do_reset();
    l = '0;
    l[23:16] = 8'd10;
    step(4'b0100, l, 1'b0, 1'b0);
    reached = 0;
    for (int k = 0; k < 20 && !reached; k++) begin
      if (m_count == 6) reached = 1;
      else step('0, l, 1'b0, 1'b0);
    end
    check("ab_reached", 32'(reached), 32'd1);
    step('0, l, 1'b1, 1'b0);
    check("ab_grant", 32'(bus.grant), 32'd0);
    check("ab_done", 32'(bus.done), 32'd0);
    check("ab_count", 32'(bus.count), 32'd0);
    check("ab_total", 32'(bus.done_total), 32'd0);
    step('0, l, 1'b0, 1'b0);
    check("ab_no_late_done", 32'(bus.done), 32'd0);

    // Reset in the middle of a requester 1 job.
    do_reset();
    l = '0;
    l[15:8] = 8'd20;
    step(4'b0010, l, 1'b0, 1'b0);
    reached = 0;
    for (int k = 0; k < 30 && !reached; k++) begin
      if (m_count == 12) reached = 1;
      else step('0, l, 1'b0, 1'b0);
    end
    check("mr_reached", 32'(reached), 32'd1);
    step('0, l, 1'b0, 1'b1);
    check("mr_grant", 32'(bus.grant), 32'd0);
    check("mr_busy", 32'(bus.busy), 32'd0);
    check("mr_count", 32'(bus.count), 32'd0);
    step(4'b0011, l, 1'b0, 1'b0);
    check("mr_first_winner", 32'(bus.grant), 32'd1);

    // Near-expiry warning for len 8 (fires once) and len 3 (never).
    for (int t = 0; t < 2; t++) begin
      do_reset();
      l = '0;
      l[7:0] = (t == 0) ? 8'd8 : 8'd3;
      wcnt = 0;
      step(4'b0001, l, 1'b0, 1'b0);
      for (int k = 0; k < 12; k++) begin
        if (bus.warn) wcnt++;
        step('0, l, 1'b0, 1'b0);
      end
`ifdef TIMER_ARB_WARN_EN
      check("warn_cycles", 32'(wcnt), (t == 0) ? 32'd1 : 32'd0);
`else
      check("warn_cycles", 32'(wcnt), 32'd0);
`endif
    end

    // done_total wraps after 256 completions.
    do_reset();
    for (int j = 1; j <= 256; j++) begin
      step(4'b0001, '0, 1'b0, 1'b0);
      step(4'b0001, '0, 1'b0, 1'b0);
      if (j == 255) check("wrap_255", 32'(bus.done_total), 32'd255);
      if (j == 256) check("wrap_0", 32'(bus.done_total), 32'd0);
    end

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      for (int i = 0; i < N; i++)
        l[i*W +: W] = ($urandom_range(0, 49) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      step(r, l, ($urandom_range(0, 24) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_arbiter.md
# countdown_arbiter

Shares a single WIDTH-bit down counter between N_REQ requesters. Requests are granted in round-robin order. On each grant the block loads the winner's interval length, counts it down to zero, and signals completion back to that requester. It sits between the requester blocks and the shared timing resource, and adds abort, a completed-job tally and an optional near-expiry warning.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- WIDTH, 8: counter and length width.
- WARN_LEVEL, 5: remaining count at which warn fires. Only used with the macro.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  one clock; reset is synchronous and active-high.
- req  input  N_REQ  request per requester; level-sensitive.
- len  input  N_REQ*WIDTH  packed lengths, requester i at bits [i*WIDTH +: WIDTH].
- abort  input  1  terminates the running job.
- grant  output  N_REQ  one-hot owner of the counter; all zero when idle.
- busy  output  1  high while in RUN.
- count  output  WIDTH  current counter value.
- done  output  N_REQ  one-cycle completion pulse to the owning requester.
- done_total  output  8  number of completed jobs; wraps 255 -> 0.
- warn  output  1  near-expiry indicator; constant 0 without the macro.

## Operation
- States: IDLE and RUN. busy = (state == RUN).
- IDLE:
  - If any req bit is high, pick the first set bit scanning upward from (last_grant+1) mod N_REQ.
  - On that edge: grant <= onehot(i), count <= len[i], last_grant <= i, state <= RUN.
  - With no request, state and count hold.
- RUN, evaluated in priority order:
  - abort = 1: state <= IDLE, grant <= 0, count <= 0. No done pulse; done_total is unchanged.
  - count == 0: done[i] <= 1 for one cycle, grant <= 0, done_total <= done_total + 1, state <= IDLE.
  - Otherwise: count <= count - 1.
- req and len are ignored during RUN. Dropping req mid-job does not cancel the job. len is sampled only at the grant edge.
- A requester must deassert req in the cycle its done is high. If req is still high, it is arbitrated as a new request with lowest priority among the requesters.
- abort in IDLE has no effect.
- Reset values: state IDLE, grant 0, count 0, done 0, done_total 0, warn 0, and last_grant = N_REQ-1, so requester 0 has first priority.
- Reset overrides everything, including a running job. The active job is dropped with no done pulse.

## Timing
- From the req sample edge to grant high: 1 cycle (registered).
- From grant high to done high: len+1 cycles.
  - len = 0 gives done 1 cycle after grant.
  - len = 255 gives done 256 cycles after grant.
- done and the grant deassertion occur on the same edge. The following cycle is IDLE.
- Back-to-back jobs: a new grant is possible on the edge after done. Minimum turnaround between grants is len+2 cycles.
- abort has 1-cycle latency: grant is low on the next cycle.
- done_total updates on the same edge as the done pulse.
- count is held at 0 while idle after a completion or abort.

## Configuration
- TIMER_ARB_WARN_EN defined:
  - warn = busy && (count == WARN_LEVEL), combinational.
  - High for exactly one cycle per job when len >= WARN_LEVEL; never high when len < WARN_LEVEL.
  - Suppressed by abort only from the cycle after abort takes effect.
- TIMER_ARB_WARN_EN undefined: warn is tied to 0, with no comparator logic. All other behaviour is identical.

## Test plan
- Single job: reset, then req=0001, len[0]=3. Expect grant=0001 one cycle later, count 3,2,1,0, done[0] pulse 4 cycles after grant, done_total=1.
- Round-robin: req=1111 held continuously, all len=0. Expect grants in order 0,1,2,3,0, each with done 1 cycle after grant and a new grant on the following cycle.
- Abort: len[2]=10, assert abort when count=6. Expect grant=0 next cycle, no done[2] pulse, done_total unchanged, count=0.
- Reset mid-job: len[1]=20, assert rst when count=12. Expect all outputs at reset values the next cycle, then requester 0 winning first if req=0011.
- Warn, macro defined: len=8. Expect warn high exactly in the cycle count=5, and no warn for len=3. Without the macro, warn stays 0.
- Wrap: run 256 len=0 jobs. Expect done_total to go 255 -> 0.
